// File: rtl/j1_boot_loader.sv
// j1_boot_loader: boot sequencer for the J1 core.
// Holds the CPU in reset, receives a framed firmware image as a byte stream,
// packs it into 16-bit words written to code/data RAM, and releases the CPU
// only once the trailing checksum matches. A reload pulse in RUN returns to
// load mode.
//
// Frame: N_lo, N_hi, 2N data bytes (low byte first per word), checksum byte
// (8-bit sum of the data bytes only).
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_data/in_valid    byte stream input
//   in_ready            loader accepts a byte this cycle
//   reload              request to re-enter load mode (RUN only)
//   mem_we/addr/wdata   RAM write port, one-cycle strobe
//   cpu_reset           active-high reset to the J1 core
//   done                image loaded and CPU running
//   error               sticky frame-error flag
//   words_loaded        words written in the current or last frame
//
// state   | meaning
// IDLE    | waiting for N_lo
// HDR_HI  | waiting for N_hi, capacity check
// DATA_LO | waiting for low byte of next word
// DATA_HI | waiting for high byte, write issued next cycle
// CSUM    | waiting for checksum byte
// RUN     | CPU released
// ERR     | one-cycle frame error, then IDLE
module j1_boot_loader #(
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int          WLW = ADDR_W + 1;
  localparam int          GW  = $clog2(TIMEOUT + 1);
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, DATA_LO, DATA_HI, CSUM, RUN, ERR
  } state_t;

  state_t          state;
  logic [7:0]      n_lo;
  logic [7:0]      lo_byte;
  logic [7:0]      csum;
  logic [WLW-1:0]  n_words;
  logic [GW-1:0]   gap;
  logic            accept;
  logic            timeout_hit;
  logic [WLW-1:0]  wl_next;

  assign accept      = in_valid & in_ready;
  assign timeout_hit = (gap == GW'(TIMEOUT - 1)) && !accept;
  assign wl_next     = words_loaded + WLW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      csum         <= '0;
      n_lo         <= '0;
      lo_byte      <= '0;
      n_words      <= '0;
      gap          <= '0;
    end else begin
      mem_we <= 1'b0;

      // Gap counter only runs while a frame is in progress.
      if (accept)
        gap <= '0;
      else if (state inside {HDR_HI, DATA_LO, DATA_HI, CSUM})
        gap <= gap + GW'(1);

      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            n_lo         <= in_data;
            error        <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            state        <= HDR_HI;
          end
        end

        HDR_HI: begin
          if (accept) begin
            if ({1'b0, in_data, n_lo} > CAP) begin
              state    <= ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              // Capacity check above guarantees N fits in WLW bits.
              n_words <= WLW'({in_data, n_lo});
              state   <= ({in_data, n_lo} == 16'd0) ? CSUM : DATA_LO;
            end
          end else if (timeout_hit) begin
            state    <= ERR;
            error    <= 1'b1;
            in_ready <= 1'b0;
          end
        end

        DATA_LO: begin
          if (accept) begin
            lo_byte <= in_data;
            csum    <= csum + in_data;
            state   <= DATA_HI;
          end else if (timeout_hit) begin
            state    <= ERR;
            error    <= 1'b1;
            in_ready <= 1'b0;
          end
        end

        DATA_HI: begin
          if (accept) begin
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[ADDR_W-1:0];
            mem_wdata    <= {in_data, lo_byte};
            words_loaded <= wl_next;
            csum         <= csum + in_data;
            state        <= (wl_next == n_words) ? CSUM : DATA_LO;
          end else if (timeout_hit) begin
            state    <= ERR;
            error    <= 1'b1;
            in_ready <= 1'b0;
          end
        end

        CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end else if (timeout_hit) begin
            state    <= ERR;
            error    <= 1'b1;
            in_ready <= 1'b0;
          end
        end

        RUN: begin
          in_ready <= 1'b0;
          if (reload) begin
            state     <= IDLE;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        ERR: begin
          cpu_reset <= 1'b1;
          done      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_j1_boot_loader.sv
module tb_j1_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [4:0]  words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;
  int base;
  int cycles;
  logic        prev_we = 1'b0;
  logic [3:0]  last_addr;
  logic [15:0] last_data;

  always #5 clk = ~clk;

  j1_boot_loader #(.ADDR_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  // Write monitor: records writes and flags a strobe held for two cycles.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      we_count++;
      last_addr = mem_addr;
      last_data = mem_wdata;
      n_checks++;
      if (prev_we) begin
        n_fail++;
        $display("FAIL mem_we_pulse: got two consecutive cycles high, required single cycle");
      end
    end
    prev_we = mem_we;
  end

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        rdy;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wd;
    logic        cr;
    logic        dn;
    logic        er;
    logic [4:0]  wl;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 0);
    check({tag, "_mem_we"},    32'(mem_we), 0);
    check({tag, "_mem_addr"},  32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 1);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_error"},     32'(error), 0);
    check({tag, "_words"},     32'(words_loaded), 0);
  endtask

  initial begin
    // Normal load 03 00 34 12 CD AB 01 00 BF, then one ignored byte in RUN.
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{1'b1, 8'h03, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[2]  = '{1'b1, 8'h00, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[3]  = '{1'b1, 8'h34, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[4]  = '{1'b1, 8'h12, 1'b1, 1'b1, 4'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 5'd1};
    vecs[5]  = '{1'b1, 8'hCD, 1'b1, 1'b0, 4'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 5'd1};
    vecs[6]  = '{1'b1, 8'hAB, 1'b1, 1'b1, 4'd1, 16'hABCD, 1'b1, 1'b0, 1'b0, 5'd2};
    vecs[7]  = '{1'b1, 8'h01, 1'b1, 1'b0, 4'd1, 16'hABCD, 1'b1, 1'b0, 1'b0, 5'd2};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b1, 4'd2, 16'h0001, 1'b1, 1'b0, 1'b0, 5'd3};
    vecs[9]  = '{1'b1, 8'hBF, 1'b0, 1'b0, 4'd2, 16'h0001, 1'b0, 1'b1, 1'b0, 5'd3};
    vecs[10] = '{1'b1, 8'h55, 1'b0, 1'b0, 4'd2, 16'h0001, 1'b0, 1'b1, 1'b0, 5'd3};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    step();
    step();
    check_reset_outputs("por");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      step();
      check($sformatf("v%0d_in_ready", i),  32'(in_ready),     32'(vecs[i].rdy));
      check($sformatf("v%0d_mem_we", i),    32'(mem_we),       32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("v%0d_mem_addr", i),  32'(mem_addr),  32'(vecs[i].addr));
        check($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wd));
      end
      check($sformatf("v%0d_cpu_reset", i), 32'(cpu_reset),    32'(vecs[i].cr));
      check($sformatf("v%0d_done", i),      32'(done),         32'(vecs[i].dn));
      check($sformatf("v%0d_error", i),     32'(error),        32'(vecs[i].er));
      check($sformatf("v%0d_words", i),     32'(words_loaded), 32'(vecs[i].wl));
    end
    check("normal_we_count", 32'(we_count), 3);

    // Reload with a byte presented in the same cycle: only reload acts.
    reload = 1'b1; in_valid = 1'b1; in_data = 8'h05;
    step();
    reload = 1'b0; in_valid = 1'b0;
    check("reload_cpu_reset", 32'(cpu_reset), 1);
    check("reload_done",      32'(done), 0);
    check("reload_in_ready",  32'(in_ready), 1);
    step();
    check("reload_byte_ignored_words", 32'(words_loaded), 3);

    base = we_count;
    send(8'h01); send(8'h00); send(8'h78); send(8'h56);
    check("reload_frame_we",    32'(mem_we), 1);
    check("reload_frame_addr",  32'(mem_addr), 0);
    check("reload_frame_wdata", 32'(mem_wdata), 32'h5678);
    send(8'hCE);
    check("reload_frame_done",  32'(done), 1);
    check("reload_frame_cpu",   32'(cpu_reset), 0);
    check("reload_frame_words", 32'(words_loaded), 1);
    check("reload_frame_wecnt", 32'(we_count - base), 1);

    // Empty image.
    pulse_reload();
    base = we_count;
    send(8'h00); send(8'h00); send(8'h00);
    check("empty_done",  32'(done), 1);
    check("empty_words", 32'(words_loaded), 0);
    check("empty_wecnt", 32'(we_count - base), 0);

    // Bad checksum, then error clear, then oversize header 11 00.
    pulse_reload();
    base = we_count;
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    check("badcs_we",    32'(mem_we), 1);
    check("badcs_addr",  32'(mem_addr), 0);
    check("badcs_wdata", 32'(mem_wdata), 32'h2211);
    send(8'h00);
    check("badcs_error",     32'(error), 1);
    check("badcs_cpu_reset", 32'(cpu_reset), 1);
    check("badcs_done",      32'(done), 0);
    check("badcs_err_ready", 32'(in_ready), 0);
    step();
    check("badcs_idle_ready", 32'(in_ready), 1);
    check("badcs_idle_error", 32'(error), 1);
    send(8'h11);
    check("error_cleared", 32'(error), 0);
    send(8'h00);
    check("oversize_error", 32'(error), 1);
    check("oversize_ready", 32'(in_ready), 0);
    step();
    check("oversize_idle_ready", 32'(in_ready), 1);
    check("badcs_oversize_wecnt", 32'(we_count - base), 1);

    // Timeout mid-word.
    base = we_count;
    send(8'h02); send(8'h00); send(8'hAA);
    cycles = 0;
    while (!error && cycles < 40) begin
      step();
      cycles++;
    end
    check("timeout_cycles", 32'(cycles), 16);
    check("timeout_error",  32'(error), 1);
    check("timeout_cpu",    32'(cpu_reset), 1);
    check("timeout_words",  32'(words_loaded), 0);
    check("timeout_wecnt",  32'(we_count - base), 0);
    step();

    // Reset mid-frame after one write.
    send(8'h03); send(8'h00); send(8'h34); send(8'h12);
    check("midrst_we", 32'(mem_we), 1);
    reset = 1'b1;
    step();
    check_reset_outputs("midrst");
    reset = 1'b0;
    step();
    check("midrst_ready_back", 32'(in_ready), 1);
    base = we_count;
    send(8'h03); send(8'h00); send(8'h34); send(8'h12); send(8'hCD);
    send(8'hAB); send(8'h01); send(8'h00); send(8'hBF);
    check("midrst_done",      32'(done), 1);
    check("midrst_cpu",       32'(cpu_reset), 0);
    check("midrst_words",     32'(words_loaded), 3);
    check("midrst_wecnt",     32'(we_count - base), 3);
    check("midrst_last_addr", 32'(last_addr), 2);
    check("midrst_last_data", 32'(last_data), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
